// File: rtl/clk_en_gen_multi_if.sv
// clk_en_gen_multi_if: run gates, sync, divisor writes and enable/pending outputs of the multi-channel enable generator
interface clk_en_gen_multi_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8
);
   logic [NUM_CH-1:0] ch_run;
   logic              sync_pulse;
   logic              div_we;
   logic [2:0]        div_sel;
   logic [CNT_W-1:0]  div_val;
   logic [NUM_CH-1:0] clk_en;
   logic [NUM_CH-1:0] div_pend;
   modport master (
      output ch_run, sync_pulse, div_we, div_sel, div_val,
      input  clk_en, div_pend
   );
   modport slave (
      input  ch_run, sync_pulse, div_we, div_sel, div_val,
      output clk_en, div_pend
   );
endinterface

// File: rtl/clk_en_gen_multi.sv
// clk_en_gen_multi: NUM_CH single-cycle enable strobes with shadowed runtime divisors, run gates and global phase sync
module clk_en_gen_multi #(
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 23
) (
   input logic             clk,
   input logic             n_rst,
   clk_en_gen_multi_if.slave bus
);
   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [CNT_W-1:0]  act [NUM_CH];
   logic [CNT_W-1:0]  shd [NUM_CH];
   logic [CNT_W-1:0]  lim [NUM_CH];
   logic [NUM_CH-1:0] wrap;
   logic [NUM_CH-1:0] apply;
   logic [NUM_CH-1:0] wr;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] pend;
   assign bus.clk_en   = en;
   assign bus.div_pend = pend;
   // terminal count (divisor 0 behaves as 1), wrap, apply point and write decode per channel
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         lim[i]   = act[i] == '0 ? '0 : act[i] - 1'b1;
         wrap[i]  = bus.ch_run[i] && cnt[i] == lim[i];
         apply[i] = wrap[i] || bus.sync_pulse || !bus.ch_run[i];
         wr[i]    = bus.div_we && bus.div_sel == 3'(i);
      end
   end
   // counters, strobes and divisor shadow/active registers; a write on an apply edge goes straight to active
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] <= '0;
            act[i] <= CNT_W'(DEF_DIV);
            shd[i] <= CNT_W'(DEF_DIV);
         end
         en   <= '0;
         pend <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]  <= (bus.sync_pulse || !bus.ch_run[i] || wrap[i]) ? '0 : cnt[i] + 1'b1;
            en[i]   <= wrap[i] && !bus.sync_pulse;
            act[i]  <= apply[i] ? (wr[i] ? bus.div_val : shd[i]) : act[i];
            shd[i]  <= wr[i] ? bus.div_val : shd[i];
            pend[i] <= wr[i] ? !apply[i] : pend[i] && !apply[i];
         end
      end
   end
endmodule

// File: tb/tb_clk_en_gen_multi.sv
// tb_clk_en_gen_multi: directed scoreboard bench for clk_en_gen_multi strobe timing, divisor shadowing, sync and reset
module tb_clk_en_gen_multi;
   logic clk;
   logic n_rst;
   int   cyc;
   int   n_vec;
   int   n_err;
   int   q0[$];
   int   q1[$];
   clk_en_gen_multi_if #(.NUM_CH(2), .CNT_W(8)) bus ();
   clk_en_gen_multi #(.NUM_CH(2), .CNT_W(8), .DEF_DIV(23)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask
   task automatic to_edge(input int e);
      while (cyc < e) @(negedge clk);
   endtask
   task automatic wr_div(input int sel, input int val, input int e);
      to_edge(e - 1);
      bus.div_we  = 1'b1;
      bus.div_sel = 3'(sel);
      bus.div_val = 8'(val);
      @(negedge clk);
      bus.div_we  = 1'b0;
   endtask
   // monitor: every strobe seen pops its channel's expected edge number
   always @(negedge clk) begin
      if (n_rst) begin
         if (bus.clk_en[0]) begin
            if (q0.size() == 0) chk("strobe0_unexpected", cyc, -1);
            else chk("strobe0", cyc, q0.pop_front());
         end
         if (bus.clk_en[1]) begin
            if (q1.size() == 0) chk("strobe1_unexpected", cyc, -1);
            else chk("strobe1", cyc, q1.pop_front());
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog at edge %0d: got timeout, want finish", cyc);
      $fatal(1, "watchdog");
   end
   initial begin
      n_vec = 0;
      n_err = 0;
      n_rst = 1'b0;
      bus.ch_run = 2'b00;
      bus.sync_pulse = 1'b0;
      bus.div_we = 1'b0;
      bus.div_sel = 3'd0;
      bus.div_val = 8'd0;
      #12;
      chk("reset_clk_en", int'(bus.clk_en), 0);
      chk("reset_div_pend", int'(bus.div_pend), 0);
      to_edge(3);
      n_rst = 1'b1;
      // default divisor 23, then 5 applied at the wrap ending the second period
      q0.push_back(28);
      q0.push_back(51);
      for (int t = 56; t <= 76; t += 5) q0.push_back(t);
      to_edge(5);
      bus.ch_run = 2'b01;
      wr_div(0, 5, 39);
      chk("pend_after_write", int'(bus.div_pend), 1);
      to_edge(50);
      chk("pend_held_to_wrap", int'(bus.div_pend), 1);
      to_edge(51);
      chk("pend_cleared_at_wrap", int'(bus.div_pend), 0);
      // channel 1 stopped: writes 0 then 1 apply immediately, then runs at divide-by-1
      wr_div(1, 0, 60);
      chk("pend1_write0_stopped", int'(bus.div_pend), 0);
      wr_div(1, 1, 62);
      chk("pend1_write1_stopped", int'(bus.div_pend), 0);
      for (int t = 65; t <= 69; t++) q1.push_back(t);
      to_edge(64);
      bus.ch_run = 2'b11;
      to_edge(69);
      bus.ch_run = 2'b01;
      // divisors 7 and 3, sync on a channel-0 wrap edge
      wr_div(1, 3, 72);
      wr_div(0, 7, 73);
      chk("pend0_div7", int'(bus.div_pend), 1);
      to_edge(76);
      chk("pend0_div7_applied", int'(bus.div_pend), 0);
      q0.push_back(83);
      q0.push_back(90);
      q0.push_back(104);
      q0.push_back(111);
      q0.push_back(118);
      for (int t = 83; t <= 95; t += 3) q1.push_back(t);
      for (int t = 100; t <= 121; t += 3) q1.push_back(t);
      to_edge(80);
      bus.ch_run = 2'b11;
      to_edge(96);
      bus.sync_pulse = 1'b1;
      @(negedge clk);
      bus.sync_pulse = 1'b0;
      // out-of-range select leaves everything alone
      wr_div(5, 1, 101);
      chk("pend_sel_out_of_range", int'(bus.div_pend), 0);
      // pending write then asynchronous reset mid-count
      wr_div(0, 9, 121);
      #1;
      chk("pre_reset_clk_en", int'(bus.clk_en), 2);
      chk("pre_reset_div_pend", int'(bus.div_pend), 1);
      n_rst = 1'b0;
      #1;
      chk("async_reset_clk_en", int'(bus.clk_en), 0);
      chk("async_reset_div_pend", int'(bus.div_pend), 0);
      #2;
      n_rst = 1'b1;
      q0.push_back(144);
      q0.push_back(167);
      q1.push_back(144);
      q1.push_back(167);
      to_edge(150);
      chk("post_reset_div_pend", int'(bus.div_pend), 0);
      to_edge(170);
      bus.ch_run = 2'b00;
      to_edge(172);
      chk("missing_strobes0", q0.size(), 0);
      chk("missing_strobes1", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/clk_en_gen_multi.md
Name: clk_en_gen_multi

Overview:
- Parametrised successor to the fixed divide-by-23 clock-enable generator.
- Produces NUM_CH independent single-cycle clock-enable strobes from one clock.
- Each channel has:
  - a runtime-programmable divisor, updated glitch-free through a shadow register;
  - a per-channel run gate.
- A global sync input phase-aligns all channels.
- Feeds the serial interface and sampling logic that previously used the fixed-ratio enable.

Parameters:
- NUM_CH, 2: number of independent enable channels (1..8).
- CNT_W, 8: width of divisor and counter; legal divisor range 1..2^CNT_W-1.
- DEF_DIV, 23: divisor loaded into every channel at reset (1..2^CNT_W-1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- ch_run  in  NUM_CH  per-channel run gate; bit i high = channel i counting.
- sync_pulse  in  1  single-cycle request to restart all channels in phase.
- div_we  in  1  divisor write strobe.
- div_sel  in  3  target channel index for div_we.
- div_val  in  CNT_W  divisor value to write.
- clk_en  out  NUM_CH  registered enable strobes, one per channel.
- div_pend  out  NUM_CH  bit i high = new divisor written, not yet applied.

Behaviour:
- Reset (n_rst low, asynchronous, takes effect immediately even mid-count):
  - all counters = 0; active and shadow divisors = DEF_DIV;
  - clk_en = 0; div_pend = 0.
- Per channel i, divisor N = active divisor. A stored value of 0 is treated as 1.
- Counter cnt_i runs 0..N-1:
  - at an edge with ch_run[i]=1: if cnt_i == N-1 then cnt_i <= 0 and clk_en[i] <= 1; else cnt_i <= cnt_i+1 and clk_en[i] <= 0.
- Period and width:
  - clk_en[i] is high exactly one cycle in every N while running.
  - The first strobe is high in the cycle after the N-th edge at which ch_run[i] is sampled high.
  - N=1: clk_en[i] high every cycle, starting the cycle after the first run edge.
- Stop: an edge with ch_run[i]=0 sets cnt_i <= 0 and clk_en[i] <= 0. Restarting begins a full period from 0; there is no partial-period carry-over.
- Divisor write: at an edge with div_we=1 and div_sel<NUM_CH:
  - shadow_i <= div_val; div_pend[i] <= 1.
  - div_sel >= NUM_CH is ignored entirely.
  - A second write before the shadow is applied overwrites the shadow; the last value wins.
- Apply points: the shadow is copied to active and div_pend[i] cleared at:
  - (a) a wrap edge (cnt_i == N-1 with run);
  - (b) a sync edge;
  - (c) any edge while ch_run[i]=0.
  The active divisor therefore never changes mid-period.
- Write coinciding with an apply edge: div_val bypasses the shadow and becomes active at that edge; div_pend[i] stays 0.
- Sync: at an edge with sync_pulse=1:
  - every channel sets cnt_i <= 0 and clk_en[i] <= 0 and applies its pending shadow;
  - running channels then strobe N_i cycles after the sync edge;
  - sync has priority over a coincident wrap, so no strobe is issued for that wrap.
- Sync while a channel is stopped: the channel stays stopped; its pending shadow is still applied.
- No combinational path from any input to clk_en or div_pend.

Test Plan:
- Reset, then ch_run=2'b01, default divisor 23 → clk_en[0] one-cycle pulses exactly 23 cycles apart, the first in the cycle after the 23rd run edge; clk_en[1] stays 0.
- Write div_val=5 to channel 0 mid-period (cnt=10) → div_pend[0]=1 until the current 23-cycle period ends; subsequent pulses are 5 cycles apart; no short or long period in between.
- Write div_val=0, then div_val=1, to channel 1 while stopped, then run → div_pend[1] never seen high after the apply edge; clk_en[1] high continuously from the cycle after the first run edge.
- Channels at divisors 7 and 3, free-running, sync_pulse asserted on a channel-0 wrap edge → no strobe for that wrap; the next pulses occur 7 and 3 cycles after the sync edge respectively.
- Write with div_sel=5 (NUM_CH=2) → no change to divisors or div_pend; pulse spacing unchanged.
- Assert n_rst low for one half-cycle mid-count, asynchronous to clk → clk_en and div_pend drop immediately; after release the divisor is 23 and a full 23-cycle first period follows.
